pulp_level_shifter_in_ctrl: RTL and testbench
=============================================

Name: pulp_level_shifter_in_ctrl

Overview:
- Receive-side controller for signals entering this always-on clock domain from a switchable voltage/power domain.
- Synchronizes the remote bus and the remote power-good flag.
- Clamps the bus to a safe constant while the remote domain is off, settling or isolated.
- Exposes a level-type isolation request/acknowledge handshake to the power manager.

Parameters:
- WIDTH, 8, bus width crossing the domain boundary.
- SYNC_STAGES, 2, synchronizer flop depth for pwr_ok_i and in_i; legal range >=2.
- STABLE_CYCLES, 4, cycles in SETTLE before the bus is trusted; legal range >=1.
- CLAMP_VALUE, '0 (WIDTH bits), value driven on out_o whenever not ACTIVE.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- in_i  in  WIDTH  raw bus from the remote domain, asynchronous to clk_i.
- pwr_ok_i  in  1  remote domain power-good, asynchronous.
- iso_req_i  in  1  isolation request from the power manager; level.
- iso_ack_o  out  1  high when the bus is clamped/isolated.
- valid_o  out  1  high when out_o carries live remote data.
- out_o  out  WIDTH  registered, clamped/synchronized bus.

Behaviour:
- Reset (rst_i high at an edge):
  - state=ISO; pwr sync chain=0; data sync chain=CLAMP_VALUE; cnt=0.
  - out_o=CLAMP_VALUE, valid_o=0, iso_ack_o=1.
  - Reset mid-operation from any state has the same result on the next edge.
- Synchronizers: pwr_ok_i and in_i each pass through SYNC_STAGES flops every cycle, regardless of state. pwr_s/dat_s = last stage.
- ISO:
  - If pwr_s=1 and iso_req_i=0: go to SETTLE, cnt<=0.
  - Otherwise stay in ISO.
- SETTLE:
  - If pwr_s=0 or iso_req_i=1: go to ISO. Abort has priority over the count.
  - Else if cnt==STABLE_CYCLES-1: go to ACTIVE.
  - Else cnt<=cnt+1.
  - cnt width is $clog2(STABLE_CYCLES+1); cnt never wraps.
- ACTIVE:
  - If pwr_s=0 or iso_req_i=1: go to ISO.
  - Otherwise stay in ACTIVE.
- Outputs:
  - valid_o=(state==ACTIVE) and iso_ack_o=(state!=ACTIVE), both decoded from the state register only.
  - out_o register: loads dat_s when next_state==ACTIVE, else CLAMP_VALUE. out_o therefore clamps on the same edge at which valid_o falls.
- Handshake:
  - iso_ack_o rises 1 cycle after iso_req_i is sampled high in ACTIVE.
  - iso_ack_o stays high while iso_req_i=1.
  - After iso_req_i falls with pwr_s=1: ISO->SETTLE takes 1 cycle, then STABLE_CYCLES cycles pass before ack falls and valid rises.
- Latency:
  - pwr_ok_i rise to valid_o=1: SYNC_STAGES+1+STABLE_CYCLES edges (7 with defaults).
  - in_i change to out_o while in ACTIVE: SYNC_STAGES+1 edges.
- Simultaneous events:
  - pwr_s falling and iso_req_i rising in the same cycle: single transition to ISO.
  - pwr_s glitch shorter than one sample during SETTLE: restart through ISO; cnt resets.

Optional Feature:
- Macro: PULP_LVL_SHIFT_IN_FILTER_EN.
- With the macro defined:
  - Add a register filt_q <= dat_s every cycle; reset value CLAMP_VALUE.
  - While staying in ACTIVE, out_o loads dat_s only when dat_s==filt_q (whole word); otherwise it holds.
  - On the transition into ACTIVE, out_o loads dat_s unconditionally.
  - Steady-state in_i latency becomes SYNC_STAGES+2.
  - A word change that persists in dat_s for only 1 cycle never appears on out_o.
- Without the macro: no filt_q register; behaviour is exactly as in Behaviour.

Test Plan:
1. Reset and power-up: rst_i=1 for 3 cycles, then pwr_ok_i=1, iso_req_i=0, in_i=8'hA5.
   - Required: out_o=8'h00, valid_o=0, iso_ack_o=1 until edge 7 after pwr_ok_i.
   - Then valid_o=1, iso_ack_o=0, out_o=8'hA5.
2. ACTIVE data path: in_i 8'hA5 -> 8'h3C.
   - Required: out_o=8'h3C exactly 3 edges later; 4 edges with PULP_LVL_SHIFT_IN_FILTER_EN.
3. Isolation handshake: iso_req_i=1 in ACTIVE.
   - Required: next edge iso_ack_o=1, valid_o=0, out_o=8'h00.
   - Then iso_req_i=0: ack falls after 1+4=5 edges.
4. Power loss in SETTLE: pwr_ok_i drops 2 cycles into SETTLE.
   - Required: return to ISO, valid_o never rises.
   - On pwr_ok_i return, the full 7-edge sequence restarts.
5. Reset mid-ACTIVE: rst_i=1 for 1 cycle while out_o=8'h3C.
   - Required: next edge out_o=8'h00, valid_o=0, iso_ack_o=1.
6. Filter (macro on): one-cycle pulse in_i=8'hFF inside steady 8'h3C.
   - Required: out_o stays 8'h3C throughout.

Source files
------------

// File: rtl/pulp_level_shifter_in_ctrl.sv
// Receive-side controller for a bus entering from a switchable power domain: synchronizes,
// clamps while the remote side is off/settling/isolated. Optional macro: PULP_LVL_SHIFT_IN_FILTER_EN.
module pulp_level_shifter_in_ctrl #(
   parameter int unsigned      WIDTH         = 8,
   parameter int unsigned      SYNC_STAGES   = 2,
   parameter int unsigned      STABLE_CYCLES = 4,
   parameter logic [WIDTH-1:0] CLAMP_VALUE   = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] in_i,
   input  logic             pwr_ok_i,
   input  logic             iso_req_i,
   output logic             iso_ack_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] out_o
);

   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {StIso, StSettle, StActive} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]    out_q, out_d;
   logic [SYNC_STAGES-1:0] pwr_sync_q;
   logic [WIDTH-1:0]    dat_sync_q [SYNC_STAGES];
   logic                pwr_s;
   logic [WIDTH-1:0]    dat_s;
   logic                abort;

   assign pwr_s = pwr_sync_q[SYNC_STAGES-1];
   assign dat_s = dat_sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pwr_sync_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            dat_sync_q[i] <= CLAMP_VALUE;
         end
      end else begin
         pwr_sync_q    <= {pwr_sync_q[SYNC_STAGES-2:0], pwr_ok_i};
         dat_sync_q[0] <= in_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            dat_sync_q[i] <= dat_sync_q[i-1];
         end
      end
   end

   // Loss of power or a new isolation request always wins over the settle count.
   assign abort = !pwr_s || iso_req_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIso: begin
            if (!abort) begin
               state_d = StSettle;
               cnt_d   = '0;
            end
         end
         StSettle: begin
            if (abort) begin
               state_d = StIso;
            end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
               state_d = StActive;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StActive: begin
            if (abort) begin
               state_d = StIso;
            end
         end
         default: state_d = StIso;
      endcase
   end

`ifdef PULP_LVL_SHIFT_IN_FILTER_EN
   logic [WIDTH-1:0] filt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         filt_q <= CLAMP_VALUE;
      end else begin
         filt_q <= dat_s;
      end
   end

   // Inside ACTIVE only a word seen on two consecutive samples is passed on.
   always_comb begin
      out_d = CLAMP_VALUE;
      if (state_d == StActive) begin
         if (state_q != StActive || dat_s == filt_q) begin
            out_d = dat_s;
         end else begin
            out_d = out_q;
         end
      end
   end
`else
   always_comb begin
      out_d = CLAMP_VALUE;
      if (state_d == StActive) begin
         out_d = dat_s;
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIso;
         cnt_q   <= '0;
         out_q   <= CLAMP_VALUE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   assign out_o     = out_q;
   assign valid_o   = (state_q == StActive);
   assign iso_ack_o = (state_q != StActive);

endmodule

// File: tb/tb_pulp_level_shifter_in_ctrl.sv
// Scoreboard bench: stimulus queues per-edge expectations, a monitor compares after each edge.
module tb_pulp_level_shifter_in_ctrl;

   typedef struct {
      int          tag;
      logic [7:0]  out;
      logic        valid;
      logic        ack;
      string       name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_v;
   logic       pwr;
   logic       iso;
   logic       ack;
   logic       valid;
   logic [7:0] out;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

`ifdef PULP_LVL_SHIFT_IN_FILTER_EN
   localparam int DatLat = 4;
`else
   localparam int DatLat = 3;
`endif

   pulp_level_shifter_in_ctrl dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .in_i      (in_v),
      .pwr_ok_i  (pwr),
      .iso_req_i (iso),
      .iso_ack_o (ack),
      .valid_o   (valid),
      .out_o     (out)
   );

   always #5 clk = ~clk;

   // Value expected after k more rising edges from the current negedge.
   task automatic expect_at(input int k, input logic [7:0] o, input logic v, input logic a,
                            input string nm);
      exp_t e;
      e.tag = cyc + k; e.out = o; e.valid = v; e.ack = a; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic expect_clamp(input int k_from, input int k_to, input string nm);
      for (int k = k_from; k <= k_to; k++) expect_at(k, 8'h00, 1'b0, 1'b1, nm);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         checks = checks + 1;
         if (e.tag < cyc) begin
            errors = errors + 1;
            $display("FAIL %s: expectation for edge %0d not checked (now edge %0d)",
                     e.name, e.tag, cyc);
         end else if (out !== e.out || valid !== e.valid || ack !== e.ack) begin
            errors = errors + 1;
            $display("FAIL %s edge %0d: got out=%h valid=%b ack=%b, expected out=%h valid=%b ack=%b",
                     e.name, cyc, out, valid, ack, e.out, e.valid, e.ack);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; pwr = 1'b0; iso = 1'b0; in_v = 8'h00;
      // 1. reset, then power-up: valid on the 7th edge
      expect_clamp(1, 3, "reset");
      step(3);
      rst = 1'b0; pwr = 1'b1; in_v = 8'hA5;
      expect_clamp(1, 6, "powerup_clamp");
      expect_at(7, 8'hA5, 1'b1, 1'b0, "powerup_active");
      step(7);

      // 2. data path latency in ACTIVE
      in_v = 8'h3C;
      for (int k = 1; k < DatLat; k++) expect_at(k, 8'hA5, 1'b1, 1'b0, "data_old");
      expect_at(DatLat, 8'h3C, 1'b1, 1'b0, "data_new");
      step(DatLat);

      // 3. isolation handshake
      iso = 1'b1;
      expect_clamp(1, 1, "iso_ack");
      step(1);
      iso = 1'b0;
      expect_clamp(1, 4, "iso_release_clamp");
      expect_at(5, 8'h3C, 1'b1, 1'b0, "iso_release_active");
      step(5);

      // 6. one-cycle pulse: filtered out with the macro, passed through without it
      in_v = 8'hFF;
`ifdef PULP_LVL_SHIFT_IN_FILTER_EN
      for (int k = 1; k <= 5; k++) expect_at(k, 8'h3C, 1'b1, 1'b0, "pulse_filtered");
`else
      expect_at(1, 8'h3C, 1'b1, 1'b0, "pulse_pre");
      expect_at(2, 8'h3C, 1'b1, 1'b0, "pulse_pre");
      expect_at(3, 8'hFF, 1'b1, 1'b0, "pulse_seen");
      expect_at(4, 8'h3C, 1'b1, 1'b0, "pulse_post");
      expect_at(5, 8'h3C, 1'b1, 1'b0, "pulse_post");
`endif
      step(1);
      in_v = 8'h3C;
      step(4);

      // 4. power loss two cycles into SETTLE; abort lands when cnt would complete
      iso = 1'b1;
      expect_clamp(1, 8, "settle_abort");
      step(1);
      iso = 1'b0;
      step(2);
      pwr = 1'b0;
      step(5);
      pwr = 1'b1;
      expect_clamp(1, 6, "repower_clamp");
      expect_at(7, 8'h3C, 1'b1, 1'b0, "repower_active");
      step(7);

      // 5. reset mid-ACTIVE, then a full restart
      rst = 1'b1;
      expect_clamp(1, 1, "reset_mid");
      step(1);
      rst = 1'b0;
      expect_clamp(1, 6, "restart_clamp");
      expect_at(7, 8'h3C, 1'b1, 1'b0, "restart_active");
      step(7);

      step(2);
      if (exp_q.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
